// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue bus: producer write port and transmitter start/done port.
// The master side is the producer/transmitter pair; the slave is the queue.
interface uart_tx_queue_if #(
    parameter int WORD_BITS = 8,
    parameter int ADDR_BITS = 4
);
    logic                 wr_en_i;
    logic [WORD_BITS-1:0] wr_data_i;
    logic                 full_o;
    logic                 empty_o;
    logic [ADDR_BITS:0]   count_o;
    logic                 overflow_o;
    logic                 busy_o;
    logic                 tx_start_o;
    logic [WORD_BITS-1:0] tx_data_o;
    logic                 tx_done_i;

    modport master (
        output wr_en_i,
        output wr_data_i,
        output tx_done_i,
        input  full_o,
        input  empty_o,
        input  count_o,
        input  overflow_o,
        input  busy_o,
        input  tx_start_o,
        input  tx_data_o
    );

    modport slave (
        input  wr_en_i,
        input  wr_data_i,
        input  tx_done_i,
        output full_o,
        output empty_o,
        output count_o,
        output overflow_o,
        output busy_o,
        output tx_start_o,
        output tx_data_o
    );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular FIFO feeding the UART transmitter.
// A dispatcher pops one word, pulses start, then waits for done.
module uart_tx_queue #(
    parameter int WORD_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    uart_tx_queue_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WORD_BITS-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;

    logic                 r_tx_start;
    logic [WORD_BITS-1:0] r_tx_data;
    logic                 r_busy;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_pop;

    // Status flags come straight from the registered count.
    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);

    // A full queue drops the write even if a pop frees a slot this cycle.
    assign w_accept = bus.wr_en_i && !w_full;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;

    // Dispatcher next-state: pop in IDLE, one START cycle, park in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_pop) w_state_nxt = S_START;
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_done_i) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Dispatcher state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.wr_data_i;
        end
    end

    // Pointers wrap naturally at the array depth.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous accept and pop cancel out.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else begin
            unique case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered outputs; tx data only moves on the IDLE->START edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_tx_start <= (w_state_nxt == S_START);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_overflow <= bus.wr_en_i && w_full;
            if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    assign bus.full_o     = w_full;
    assign bus.empty_o    = w_empty;
    assign bus.count_o    = r_count;
    assign bus.overflow_o = r_overflow;
    assign bus.busy_o     = r_busy;
    assign bus.tx_start_o = r_tx_start;
    assign bus.tx_data_o  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench for the UART transmit queue.
// Words are queued as written and checked against each start pulse.
module tb_uart_tx_queue;
    localparam int WB = 8;
    localparam int AB = 4;

    logic clk_i = 1'b0;
    logic reset_n_i;

    always #5 clk_i = ~clk_i;

    uart_tx_queue_if #(.WORD_BITS(WB), .ADDR_BITS(AB)) bus ();

    uart_tx_queue #(.WORD_BITS(WB), .ADDR_BITS(AB)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [7:0]  sb_q [$];
    int          done_cnt   = -1;
    int          done_delay = -1;
    int          last_start = -1;
    int          last_done  = -1;
    int          n_start    = 0;
    bit          gap_en     = 1'b0;
    bit          gap_armed  = 1'b0;
    logic        busy_at_done = 1'b0;
    int          start_cnt_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @cyc %0d",
                     tag, got, exp, cyc);
        end
    endtask

    // One clock: drive done, step the edge, then score any start pulse.
    task automatic tick();
        logic       d;
        logic [7:0] e;
        d = (done_cnt == 0);
        bus.tx_done_i = d;
        if (d) busy_at_done = bus.busy_o;
        if (done_cnt >= 0) done_cnt--;
        @(posedge clk_i);
        #1;
        cyc++;
        bus.tx_done_i = 1'b0;
        if (d) begin
            last_done = cyc - 1;
            gap_armed = 1'b1;
        end
        if (bus.tx_start_o === 1'b1) begin
            n_start++;
            last_start = cyc;
            start_cnt_q.push_back(int'(bus.count_o));
            if (gap_en && gap_armed)
                chk("done_to_start", cyc - last_done, 2);
            gap_armed = 1'b0;
            if (sb_q.size() == 0) begin
                chk("spurious_start", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("tx_data", bus.tx_data_o, e);
            end
            if (done_delay >= 0) done_cnt = done_delay;
        end
    endtask

    task automatic wr(input logic [7:0] d, input bit push);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = d;
        if (push) sb_q.push_back(d);
        tick();
        bus.wr_en_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || bus.busy_o !== 1'b0) && k < budget) begin
            tick();
            k++;
        end
        chk("drain_timeout", (sb_q.size() != 0 || bus.busy_o !== 1'b0), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        int k;
        int sent;

        reset_n_i     = 1'b0;
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = '0;
        bus.tx_done_i = 1'b0;
        repeat (3) tick();

        chk("rst_count", bus.count_o, 0);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_full", bus.full_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_start", bus.tx_start_o, 0);
        chk("rst_data", bus.tx_data_o, 0);
        chk("rst_ovf", bus.overflow_o, 0);

        reset_n_i = 1'b1;
        tick();

        // Single word latency and busy window.
        done_delay = 5;
        n = cyc;
        wr(8'h41, 1'b1);
        chk("w1_count", bus.count_o, 1);
        chk("w1_nostart", bus.tx_start_o, 0);
        tick();
        chk("w1_start", bus.tx_start_o, 1);
        chk("w1_start_cyc", last_start, n + 2);
        chk("w1_empty", bus.empty_o, 1);
        chk("w1_busy", bus.busy_o, 1);
        k = 0;
        while (last_done < n + 2 && k < 50) begin
            tick();
            k++;
        end
        chk("w1_done_seen", (last_done >= n + 2), 1);
        chk("w1_busy_at_done", busy_at_done, 1);
        chk("w1_busy_after", bus.busy_o, 0);
        tick();
        chk("w1_no_restart", bus.tx_start_o, 0);

        // Burst of three with done 20 cycles after each start.
        gap_en     = 1'b1;
        gap_armed  = 1'b0;
        done_delay = 20;
        n0 = n_start;
        start_cnt_q.delete();
        wr(8'h10, 1'b1);
        wr(8'h20, 1'b1);
        wr(8'h30, 1'b1);
        chk("b_count", bus.count_o, 2);
        drain(300);
        chk("b_starts", n_start - n0, 3);
        if (start_cnt_q.size() == 3) begin
            chk("b_cnt2", start_cnt_q[1], 1);
            chk("b_cnt3", start_cnt_q[2], 0);
        end else begin
            chk("b_cnt_len", start_cnt_q.size(), 3);
        end
        gap_en = 1'b0;

        // Fill to full with dispatcher parked in WAIT.
        done_delay = -1;
        n0 = n_start;
        for (int i = 0; i < 17; i++) wr(8'h80 + 8'(i), 1'b1);
        chk("f_count", bus.count_o, 16);
        chk("f_full", bus.full_o, 1);
        chk("f_ovf_pre", bus.overflow_o, 0);
        chk("f_one_start", n_start - n0, 1);
        wr(8'hEE, 1'b0);
        chk("f_ovf", bus.overflow_o, 1);
        chk("f_count_keep", bus.count_o, 16);
        tick();
        chk("f_ovf_pulse", bus.overflow_o, 0);
        done_cnt   = 0;
        done_delay = 3;
        drain(500);
        chk("f_starts", n_start - n0, 17);
        n0 = n_start;
        repeat (5) tick();
        chk("f_no_extra", n_start - n0, 0);

        // Write coinciding with the pop of a single queued word.
        wr(8'h33, 1'b1);
        chk("s_count_pre", bus.count_o, 1);
        chk("s_idle", bus.busy_o, 0);
        wr(8'h55, 1'b1);
        chk("s_count", bus.count_o, 1);
        chk("s_start", bus.tx_start_o, 1);
        drain(200);

        // Wrap-around: 40 words streamed with the queue kept occupied.
        done_delay = 1;
        n0 = n_start;
        sent = 0;
        k = 0;
        while (sent < 40 && k < 2000) begin
            if (bus.count_o < 12) begin
                wr(8'(sent), 1'b1);
                sent++;
            end else begin
                tick();
            end
            k++;
        end
        chk("wr_sent", sent, 40);
        drain(600);
        chk("wr_starts", n_start - n0, 40);

        // Reset asserted while parked in WAIT with words queued.
        done_delay = -1;
        n0 = n_start;
        for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i), 1'b1);
        chk("r_busy_pre", bus.busy_o, 1);
        chk("r_one_start", n_start - n0, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("r_count", bus.count_o, 0);
        chk("r_start", bus.tx_start_o, 0);
        chk("r_busy", bus.busy_o, 0);
        chk("r_empty", bus.empty_o, 1);
        chk("r_data", bus.tx_data_o, 0);
        sb_q.delete();
        repeat (2) tick();
        chk("r_count_held", bus.count_o, 0);
        reset_n_i = 1'b1;
        n0 = n_start;
        done_cnt = 0;
        repeat (10) tick();
        chk("r_stray_done", n_start - n0, 0);
        chk("r_idle", bus.busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
